// File: rtl/frame_cfg_loader.sv
// Configuration-word loader: turns a valid/ready stream of {address, data} words into
// setup/strobe/hold write sequences on the switch-block configuration bus.
`timescale 1ns/1ps
module frame_cfg_loader #(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 1,
    parameter int NUM_LINES = 18,
    parameter int CNT_W     = 6
) (
    input  logic              prog_clk,
    input  logic              prog_rst_n,
    input  logic              cfg_start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              enable,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_in,
    output logic [CNT_W-1:0]  wr_count,
    output logic              cfg_done,
    output logic              cfg_err
);

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        SETUP,
        STROBE,
        HOLD,
        DONE,
        ERR
    } state_t;

    state_t state;
    state_t state_next;
    logic   last_q;
    logic   illegal;

    // Decoder index is the address without its bit-select LSB.
    assign illegal = 32'(s_addr[ADDR_W-1:1]) >= 32'(NUM_LINES);

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cfg_start) state_next = ACCEPT;
            ACCEPT:  if (s_valid) state_next = illegal ? ERR : SETUP;
            SETUP:   state_next = STROBE;
            STROBE:  state_next = HOLD;
            HOLD:    state_next = last_q ? DONE : ACCEPT;
            DONE,
            ERR:     if (cfg_start) state_next = ACCEPT;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        s_ready = 1'b0;
        enable  = 1'b0;
        case (state)
            ACCEPT:  s_ready = 1'b1;
            STROBE:  enable  = 1'b1;
            default: ;
        endcase
    end

    // Bus registers load only when a legal word is taken, i.e. on the SETUP entry edge,
    // so the latch memories see stable address/data around the strobe.
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            address  <= '0;
            data_in  <= '0;
            last_q   <= 1'b0;
            wr_count <= '0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (cfg_start) begin
                        wr_count <= '0;
                        cfg_done <= 1'b0;
                        cfg_err  <= 1'b0;
                    end
                end
                ACCEPT: begin
                    if (cfg_start) begin
                        wr_count <= '0;
                        cfg_done <= 1'b0;
                        cfg_err  <= 1'b0;
                    end
                    if (s_valid) begin
                        if (illegal) begin
                            cfg_err <= 1'b1;
                        end else begin
                            address <= s_addr;
                            data_in <= s_data;
                            last_q  <= s_last;
                        end
                    end
                end
                HOLD: begin
                    if (wr_count != '1) wr_count <= wr_count + CNT_W'(1);
                    if (last_q) cfg_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_cfg_loader.sv
// Directed bench for frame_cfg_loader: streaming loads, illegal address, back-pressure,
// reset during strobe, ignored restart mid-write and a single-word bitstream.
`timescale 1ns/1ps
module tb_frame_cfg_loader;

    logic       prog_clk;
    logic       prog_rst_n;
    logic       cfg_start;
    logic       s_valid;
    logic       s_ready;
    logic [5:0] s_addr;
    logic [0:0] s_data;
    logic       s_last;
    logic       enable;
    logic [5:0] address;
    logic [0:0] data_in;
    logic [5:0] wr_count;
    logic       cfg_done;
    logic       cfg_err;

    int checks = 0;
    int errors = 0;

    frame_cfg_loader dut (
        .prog_clk   (prog_clk),
        .prog_rst_n (prog_rst_n),
        .cfg_start  (cfg_start),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_addr     (s_addr),
        .s_data     (s_data),
        .s_last     (s_last),
        .enable     (enable),
        .address    (address),
        .data_in    (data_in),
        .wr_count   (wr_count),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic start_pulse;
        @(negedge prog_clk);
        cfg_start = 1'b1;
        s_valid   = 1'b0;
        @(negedge prog_clk);
        cfg_start = 1'b0;
    endtask

    task automatic test_reset;
        prog_rst_n = 1'b0;
        cfg_start  = 1'b0;
        s_valid    = 1'b0;
        s_addr     = '0;
        s_data     = '0;
        s_last     = 1'b0;
        repeat (2) @(negedge prog_clk);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_ready: got %0b expected 0", s_ready); end
        checks++; if (enable !== 1'b0) begin errors++; $display("[TB] FAIL reset_enable: got %0b expected 0", enable); end
        checks++; if (address !== 6'd0) begin errors++; $display("[TB] FAIL reset_address: got %0d expected 0", address); end
        checks++; if (data_in !== 1'b0) begin errors++; $display("[TB] FAIL reset_data_in: got %0b expected 0", data_in); end
        checks++; if (wr_count !== 6'd0) begin errors++; $display("[TB] FAIL reset_wr_count: got %0d expected 0", wr_count); end
        checks++; if (cfg_done !== 1'b0 || cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got done=%0b err=%0b expected 0/0", cfg_done, cfg_err); end
        prog_rst_n = 1'b1;
        s_valid    = 1'b1;
        repeat (2) @(negedge prog_clk);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL idle_s_ready: got %0b expected 0", s_ready); end
        s_valid = 1'b0;
    endtask

    task automatic test_full_load;
        int  k = 0;
        int  pulses = 0;
        int  last_cyc = 0;
        bit  pend;
        bit  prev_en = 1'b0;
        start_pulse();
        s_valid = 1'b1;
        s_addr  = 6'd0;
        s_data  = 1'b0;
        s_last  = 1'b0;
        pend    = s_ready && s_valid;
        for (int cyc = 0; cyc < 300 && !cfg_done; cyc++) begin
            @(negedge prog_clk);
            if (enable) begin
                checks++; if (prev_en) begin errors++; $display("[TB] FAIL load_double_enable: got 2 cycles expected 1"); end
                checks++; if (address !== 6'(pulses)) begin errors++; $display("[TB] FAIL load_address: got %0d expected %0d", address, pulses); end
                checks++; if (data_in !== pulses[0]) begin errors++; $display("[TB] FAIL load_data: got %0b expected %0b", data_in, pulses[0]); end
                if (pulses > 0) begin
                    checks++; if (cyc - last_cyc != 4) begin errors++; $display("[TB] FAIL load_spacing: got %0d expected 4", cyc - last_cyc); end
                end
                last_cyc = cyc;
                pulses++;
            end
            prev_en = enable;
            if (pend) begin
                k++;
                if (k < 36) begin
                    s_addr = 6'(k);
                    s_data = k[0];
                    s_last = (k == 35);
                end else begin
                    s_valid = 1'b0;
                end
            end
            pend = s_ready && s_valid;
        end
        checks++; if (pulses != 36) begin errors++; $display("[TB] FAIL load_pulses: got %0d expected 36", pulses); end
        checks++; if (wr_count !== 6'd36) begin errors++; $display("[TB] FAIL load_wr_count: got %0d expected 36", wr_count); end
        checks++; if (cfg_done !== 1'b1 || cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL load_flags: got done=%0b err=%0b expected 1/0", cfg_done, cfg_err); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL load_s_ready_after: got %0b expected 0", s_ready); end
    endtask

    task automatic test_illegal;
        start_pulse();
        s_valid = 1'b1;
        s_addr  = 6'b100100;
        s_data  = 1'b1;
        s_last  = 1'b0;
        @(negedge prog_clk);
        s_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (enable !== 1'b0) begin errors++; $display("[TB] FAIL illegal_enable: got %0b expected 0", enable); end
            checks++; if (cfg_err !== 1'b1) begin errors++; $display("[TB] FAIL illegal_cfg_err: got %0b expected 1", cfg_err); end
            checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL illegal_s_ready: got %0b expected 0", s_ready); end
            @(negedge prog_clk);
        end
        checks++; if (wr_count !== 6'd0) begin errors++; $display("[TB] FAIL illegal_wr_count: got %0d expected 0", wr_count); end
        start_pulse();
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL restart_cfg_err: got %0b expected 0", cfg_err); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL restart_s_ready: got %0b expected 1", s_ready); end
    endtask

    task automatic test_back_pressure;
        int          k = 0;
        int          pulses = 0;
        bit          pend;
        bit          chk_after = 1'b0;
        logic [5:0]  prev_addr;
        logic [0:0]  prev_data;
        start_pulse();
        s_valid   = 1'($urandom_range(0, 1));
        s_addr    = 6'd0;
        s_data    = 1'b0;
        s_last    = 1'b0;
        pend      = s_ready && s_valid;
        prev_addr = address;
        prev_data = data_in;
        for (int cyc = 0; cyc < 400 && !cfg_done; cyc++) begin
            @(negedge prog_clk);
            if (chk_after) begin
                checks++; if (address !== 6'(pulses - 1) || data_in !== prev_data) begin errors++; $display("[TB] FAIL bp_hold_stable: got %0d/%0b expected %0d/%0b", address, data_in, pulses - 1, prev_data); end
                chk_after = 1'b0;
            end
            if (enable) begin
                checks++; if (address !== 6'(pulses) || data_in !== pulses[0]) begin errors++; $display("[TB] FAIL bp_pulse: got %0d/%0b expected %0d/%0b", address, data_in, pulses, pulses[0]); end
                checks++; if (address !== prev_addr || data_in !== prev_data) begin errors++; $display("[TB] FAIL bp_setup_stable: got %0d/%0b expected %0d/%0b", prev_addr, prev_data, address, data_in); end
                pulses++;
                chk_after = 1'b1;
            end
            prev_addr = address;
            prev_data = data_in;
            if (pend) k++;
            if (k < 12) begin
                s_valid = 1'($urandom_range(0, 1));
                s_addr  = 6'(k);
                s_data  = k[0];
                s_last  = (k == 11);
            end else begin
                s_valid = 1'b0;
            end
            pend = s_ready && s_valid;
        end
        checks++; if (pulses != 12) begin errors++; $display("[TB] FAIL bp_pulses: got %0d expected 12", pulses); end
        checks++; if (wr_count !== 6'd12 || cfg_done !== 1'b1) begin errors++; $display("[TB] FAIL bp_final: got count=%0d done=%0b expected 12/1", wr_count, cfg_done); end
    endtask

    task automatic test_reset_in_strobe;
        int seen = 0;
        bit pend;
        start_pulse();
        s_valid = 1'b1;
        s_addr  = 6'd10;
        s_data  = 1'b1;
        s_last  = 1'b0;
        pend    = s_ready && s_valid;
        for (int cyc = 0; cyc < 60 && seen < 2; cyc++) begin
            @(negedge prog_clk);
            if (enable) seen++;
            if (seen < 2) begin
                if (pend) s_addr = s_addr + 6'd1;
                pend = s_ready && s_valid;
            end
        end
        checks++; if (seen != 2) begin errors++; $display("[TB] FAIL rst_strobe_timeout: got %0d pulses expected 2", seen); end
        prog_rst_n = 1'b0;
        s_valid    = 1'b0;
        #1;
        checks++; if (enable !== 1'b0) begin errors++; $display("[TB] FAIL rst_strobe_enable: got %0b expected 0", enable); end
        checks++; if (wr_count !== 6'd0) begin errors++; $display("[TB] FAIL rst_strobe_wr_count: got %0d expected 0", wr_count); end
        checks++; if (address !== 6'd0 || data_in !== 1'b0) begin errors++; $display("[TB] FAIL rst_strobe_bus: got %0d/%0b expected 0/0", address, data_in); end
        checks++; if (s_ready !== 1'b0 || cfg_done !== 1'b0 || cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_strobe_status: got rdy=%0b done=%0b err=%0b expected 0/0/0", s_ready, cfg_done, cfg_err); end
        @(negedge prog_clk);
        prog_rst_n = 1'b1;
        repeat (2) @(negedge prog_clk);
        checks++; if (enable !== 1'b0 || s_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_strobe_idle: got en=%0b rdy=%0b expected 0/0", enable, s_ready); end
    endtask

    task automatic test_start_in_setup;
        int acc = 0;
        bit pend;
        start_pulse();
        s_valid = 1'b1;
        s_addr  = 6'd0;
        s_data  = 1'b0;
        s_last  = 1'b0;
        pend    = s_ready && s_valid;
        for (int cyc = 0; cyc < 100 && acc < 4; cyc++) begin
            @(negedge prog_clk);
            if (pend) acc++;
            s_addr = 6'(acc);
            s_data = acc[0];
            pend   = s_ready && s_valid;
        end
        checks++; if (acc != 4) begin errors++; $display("[TB] FAIL setup_timeout: got %0d words expected 4", acc); end
        s_valid   = 1'b0;
        cfg_start = 1'b1;
        checks++; if (enable !== 1'b0 || address !== 6'd3) begin errors++; $display("[TB] FAIL setup_state: got en=%0b addr=%0d expected 0/3", enable, address); end
        @(negedge prog_clk);
        cfg_start = 1'b0;
        checks++; if (enable !== 1'b1 || address !== 6'd3) begin errors++; $display("[TB] FAIL setup_strobe: got en=%0b addr=%0d expected 1/3", enable, address); end
        @(negedge prog_clk);
        checks++; if (wr_count !== 6'd3) begin errors++; $display("[TB] FAIL setup_hold_count: got %0d expected 3", wr_count); end
        @(negedge prog_clk);
        checks++; if (wr_count !== 6'd4) begin errors++; $display("[TB] FAIL setup_final_count: got %0d expected 4", wr_count); end
        checks++; if (s_ready !== 1'b1 || cfg_done !== 1'b0) begin errors++; $display("[TB] FAIL setup_final_state: got rdy=%0b done=%0b expected 1/0", s_ready, cfg_done); end
    endtask

    task automatic test_single_word;
        start_pulse();
        checks++; if (wr_count !== 6'd0 || s_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_restart: got count=%0d rdy=%0b expected 0/1", wr_count, s_ready); end
        s_valid = 1'b1;
        s_addr  = 6'd5;
        s_data  = 1'b1;
        s_last  = 1'b1;
        @(negedge prog_clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        checks++; if (enable !== 1'b0 || address !== 6'd5) begin errors++; $display("[TB] FAIL single_setup: got en=%0b addr=%0d expected 0/5", enable, address); end
        @(negedge prog_clk);
        checks++; if (enable !== 1'b1 || address !== 6'd5 || data_in !== 1'b1) begin errors++; $display("[TB] FAIL single_strobe: got en=%0b addr=%0d data=%0b expected 1/5/1", enable, address, data_in); end
        @(negedge prog_clk);
        checks++; if (enable !== 1'b0 || cfg_done !== 1'b0) begin errors++; $display("[TB] FAIL single_hold: got en=%0b done=%0b expected 0/0", enable, cfg_done); end
        @(negedge prog_clk);
        checks++; if (cfg_done !== 1'b1 || wr_count !== 6'd1) begin errors++; $display("[TB] FAIL single_done: got done=%0b count=%0d expected 1/1", cfg_done, wr_count); end
        checks++; if (enable !== 1'b0 || s_ready !== 1'b0 || cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_out: got en=%0b rdy=%0b err=%0b expected 0/0/0", enable, s_ready, cfg_err); end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_illegal();
        test_back_pressure();
        test_reset_in_strobe();
        test_start_in_setup();
        test_single_word();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
